// File: rtl/delay_tester_pkg.sv
// Shared types and constants for the delay statistics block: state encoding,
// debug-select codes and the timer saturation value.
package delay_tester_pkg;

  localparam int DELAY_W_DEF = 20;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'b00,
    ST_ACCUM   = 2'b01,
    ST_PUBLISH = 2'b10
  } state_e;

  localparam logic [1:0] DBG_MIN  = 2'b00;
  localparam logic [1:0] DBG_MAX  = 2'b01;
  localparam logic [1:0] DBG_AVG  = 2'b10;
  localparam logic [1:0] DBG_LOST = 2'b11;

  // A timer that ran out of range reports all-ones; such samples are lost frames.
  localparam logic [DELAY_W_DEF-1:0] SAT_DELAY = {DELAY_W_DEF{1'b1}};

  localparam int HIST_BINS  = 8;
  localparam int HIST_CNT_W = 16;

  function automatic logic [19:0] dbg_pack(input logic [31:0] lost, input logic [31:0] cnt);
    return {lost[11:0], cnt[7:0]};
  endfunction

endpackage

// File: rtl/delay_stats_if.sv
// Sample input and result output bundle of delay_stats.
interface delay_stats_if
  import delay_tester_pkg::*;
#(
  parameter int DELAY_W = DELAY_W_DEF,
  parameter int LOST_W  = 8
);
  logic               sample_valid;
  logic [DELAY_W-1:0] sample_delay;
  logic               sample_lost;
  logic               result_valid;
  logic [DELAY_W-1:0] min_delay;
  logic [DELAY_W-1:0] max_delay;
  logic [DELAY_W-1:0] avg_delay;
  logic [LOST_W-1:0]  lost_count;

  modport master (
    output sample_valid, sample_delay, sample_lost,
    input  result_valid, min_delay, max_delay, avg_delay, lost_count
  );

  modport slave (
    input  sample_valid, sample_delay, sample_lost,
    output result_valid, min_delay, max_delay, avg_delay, lost_count
  );
endinterface

// File: rtl/delay_stats_hist.sv
// delay_hist: eight saturating delay-bin counters with a registered read port.
// Only built into delay_stats when DELAY_STATS_HIST_EN is defined.
module delay_hist
  import delay_tester_pkg::*;
#(
  parameter int DELAY_W   = DELAY_W_DEF,
  parameter int BIN_SHIFT = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_clear,
  input  logic                  i_valid,
  input  logic [DELAY_W-1:0]    i_delay,
  input  logic [2:0]            i_rd_addr,
  output logic [HIST_CNT_W-1:0] o_rd_data
);

  logic [HIST_CNT_W-1:0] r_bins [HIST_BINS];
  logic [HIST_CNT_W-1:0] r_rd_data;
  logic [DELAY_W-1:0]    w_high;
  logic [2:0]            w_bin;

  // Anything above the binned field overflows into the top bin.
  always_comb begin
    w_high = i_delay >> (BIN_SHIFT + 3);
    if (w_high != '0) begin
      w_bin = 3'd7;
    end else begin
      w_bin = i_delay[BIN_SHIFT+2:BIN_SHIFT];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      for (int b = 0; b < HIST_BINS; b++) begin
        r_bins[b] <= '0;
      end
      r_rd_data <= '0;
    end else begin
      if (i_valid && (r_bins[w_bin] != {HIST_CNT_W{1'b1}})) begin
        r_bins[w_bin] <= r_bins[w_bin] + 16'd1;
      end
      r_rd_data <= r_bins[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/delay_stats.sv
// Windowed min/max/average delay statistics with lost-frame counting.
// Optional histogram sub-block is enabled by defining DELAY_STATS_HIST_EN.
module delay_stats
  import delay_tester_pkg::*;
#(
  parameter int DELAY_W   = DELAY_W_DEF,
  parameter int WIN_LOG2  = 4,
  parameter int LOST_W    = 8,
  parameter int BIN_SHIFT = 4
) (
  input  logic          i_tx_clk,
  input  logic          i_reset,
  input  logic          i_clear,
  delay_stats_if.slave  bus,
  input  logic [1:0]    i_dbg_sel,
  output logic [19:0]   o_dbg_word,
  input  logic [2:0]    i_hist_rd_addr,
  output logic [15:0]   o_hist_rd_data
);

  localparam int SUM_W  = DELAY_W + WIN_LOG2;
  localparam int CNT_W  = WIN_LOG2 + 1;
  localparam int LSUM_W = LOST_W + 2;
  localparam logic [CNT_W-1:0]  WIN_N    = {1'b1, {WIN_LOG2{1'b0}}};
  localparam logic [LOST_W-1:0] LOST_MAX = {LOST_W{1'b1}};

  state_e              r_state;
  state_e              w_state_nxt;
  logic [DELAY_W-1:0]  r_wmin, r_wmax;
  logic [SUM_W-1:0]    r_wsum;
  logic [CNT_W-1:0]    r_wcnt;
  logic [LOST_W-1:0]   r_wlost;
  logic                r_res_valid;
  logic [DELAY_W-1:0]  r_min, r_max, r_avg;
  logic [LOST_W-1:0]   r_lost;

  logic                w_sat, w_good, w_publish;
  logic [1:0]          w_lost_inc;
  logic [DELAY_W-1:0]  w_base_min, w_base_max, w_nxt_min, w_nxt_max, w_nxt_avg;
  logic [SUM_W-1:0]    w_base_sum, w_nxt_sum, w_sum_shift;
  logic [CNT_W-1:0]    w_base_cnt, w_nxt_cnt;
  logic [LOST_W-1:0]   w_base_lost, w_nxt_lost;
  logic [LSUM_W-1:0]   w_lost_sum;
  logic [31:0]         w_min32, w_max32, w_avg32, w_lost32, w_cnt32;

  assign w_sat      = bus.sample_valid & (&bus.sample_delay);
  assign w_good     = bus.sample_valid & ~w_sat;
  assign w_lost_inc = {1'b0, bus.sample_lost} + {1'b0, w_sat};

  // Next window contents; the PUBLISH cycle starts from an empty window.
  always_comb begin
    if (r_state == ST_PUBLISH) begin
      w_base_min  = '0;
      w_base_max  = '0;
      w_base_sum  = '0;
      w_base_cnt  = '0;
      w_base_lost = '0;
    end else begin
      w_base_min  = r_wmin;
      w_base_max  = r_wmax;
      w_base_sum  = r_wsum;
      w_base_cnt  = r_wcnt;
      w_base_lost = r_wlost;
    end
    w_nxt_min = w_base_min;
    w_nxt_max = w_base_max;
    w_nxt_sum = w_base_sum;
    w_nxt_cnt = w_base_cnt;
    if (w_good) begin
      if (w_base_cnt == '0) begin
        w_nxt_min = bus.sample_delay;
        w_nxt_max = bus.sample_delay;
        w_nxt_sum = SUM_W'(bus.sample_delay);
        w_nxt_cnt = CNT_W'(1'b1);
      end else begin
        w_nxt_min = (bus.sample_delay < w_base_min) ? bus.sample_delay : w_base_min;
        w_nxt_max = (bus.sample_delay > w_base_max) ? bus.sample_delay : w_base_max;
        w_nxt_sum = w_base_sum + SUM_W'(bus.sample_delay);
        w_nxt_cnt = w_base_cnt + CNT_W'(1'b1);
      end
    end else begin
      w_nxt_cnt = w_base_cnt;
    end
    w_lost_sum = LSUM_W'(w_base_lost) + LSUM_W'(w_lost_inc);
    if (w_lost_sum > LSUM_W'(LOST_MAX)) begin
      w_nxt_lost = LOST_MAX;
    end else begin
      w_nxt_lost = w_lost_sum[LOST_W-1:0];
    end
    w_sum_shift = w_nxt_sum >> WIN_LOG2;
    w_nxt_avg   = w_sum_shift[DELAY_W-1:0];
  end

  // Results are captured on the final sample so result_valid lands in PUBLISH.
  always_comb begin
    w_state_nxt = r_state;
    w_publish   = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_good) w_state_nxt = ST_ACCUM;
        else        w_state_nxt = ST_EMPTY;
      end
      ST_ACCUM: begin
        if (w_good && (w_nxt_cnt == WIN_N)) begin
          w_state_nxt = ST_PUBLISH;
          w_publish   = 1'b1;
        end else begin
          w_state_nxt = ST_ACCUM;
        end
      end
      ST_PUBLISH: begin
        if (w_good) w_state_nxt = ST_ACCUM;
        else        w_state_nxt = ST_EMPTY;
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge i_tx_clk) begin
    if (i_reset || i_clear) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_tx_clk) begin
    if (i_reset || i_clear) begin
      r_wmin      <= '0;
      r_wmax      <= '0;
      r_wsum      <= '0;
      r_wcnt      <= '0;
      r_wlost     <= '0;
      r_res_valid <= 1'b0;
      r_min       <= '0;
      r_max       <= '0;
      r_avg       <= '0;
      r_lost      <= '0;
    end else begin
      r_wmin      <= w_nxt_min;
      r_wmax      <= w_nxt_max;
      r_wsum      <= w_nxt_sum;
      r_wcnt      <= w_nxt_cnt;
      r_wlost     <= w_nxt_lost;
      r_res_valid <= w_publish;
      if (w_publish) begin
        r_min  <= w_nxt_min;
        r_max  <= w_nxt_max;
        r_avg  <= w_nxt_avg;
        r_lost <= w_nxt_lost;
      end
    end
  end

  assign bus.result_valid = r_res_valid;
  assign bus.min_delay    = r_min;
  assign bus.max_delay    = r_max;
  assign bus.avg_delay    = r_avg;
  assign bus.lost_count   = r_lost;

  assign w_min32  = 32'(r_min);
  assign w_max32  = 32'(r_max);
  assign w_avg32  = 32'(r_avg);
  assign w_lost32 = 32'(r_lost);
  assign w_cnt32  = 32'(r_wcnt);

  always_comb begin
    case (i_dbg_sel)
      DBG_MIN:  o_dbg_word = w_min32[19:0];
      DBG_MAX:  o_dbg_word = w_max32[19:0];
      DBG_AVG:  o_dbg_word = w_avg32[19:0];
      DBG_LOST: o_dbg_word = dbg_pack(w_lost32, w_cnt32);
      default:  o_dbg_word = 20'h00000;
    endcase
  end

`ifdef DELAY_STATS_HIST_EN
  delay_hist #(
    .DELAY_W   (DELAY_W),
    .BIN_SHIFT (BIN_SHIFT)
  ) u_hist (
    .i_clk     (i_tx_clk),
    .i_reset   (i_reset),
    .i_clear   (i_clear),
    .i_valid   (w_good),
    .i_delay   (bus.sample_delay),
    .i_rd_addr (i_hist_rd_addr),
    .o_rd_data (o_hist_rd_data)
  );
`else
  logic w_unused_hist;
  assign w_unused_hist  = ^{i_hist_rd_addr, (BIN_SHIFT > 0)};
  assign o_hist_rd_data = 16'h0000;
`endif

endmodule

// File: tb/tb_delay_stats.sv
// Bench for delay_stats (WIN_LOG2=2): directed table, lost saturation,
// randomized run against a queue-based window model, histogram when enabled.
module tb_delay_stats;
  import delay_tester_pkg::*;

  localparam int DW   = 20;
  localparam int WL   = 2;
  localparam int LW   = 8;
  localparam int N    = 1 << WL;
  localparam int LMAX = (1 << LW) - 1;
  localparam int SATV = 32'h000FFFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic [1:0]  dbg_sel;
  logic [19:0] dbg_word;
  logic [2:0]  hist_addr;
  logic [15:0] hist_data;

  always #5 clk = ~clk;

  delay_stats_if #(.DELAY_W(DW), .LOST_W(LW)) bus ();

  delay_stats #(.DELAY_W(DW), .WIN_LOG2(WL), .LOST_W(LW), .BIN_SHIFT(4)) dut (
    .i_tx_clk       (clk),
    .i_reset        (rst),
    .i_clear        (clr),
    .bus            (bus),
    .i_dbg_sel      (dbg_sel),
    .o_dbg_word     (dbg_word),
    .i_hist_rd_addr (hist_addr),
    .o_hist_rd_data (hist_data)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a queue holding the open window's samples.
  int q[$];
  int m_lost, m_rv, m_min, m_max, m_avg, m_lost_out;
  bit m_pend;

  typedef struct {
    bit v; int d; bit l; bit c;
    bit rv; int mn; int mx; int av; int lo; int cnt;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit c, input bit v, input int d, input bit l);
    int ev, mn, mx;
    longint sum;
    bit sat;
    if (r || c) begin
      q.delete();
      m_lost = 0; m_pend = 0; m_rv = 0;
      m_min = 0; m_max = 0; m_avg = 0; m_lost_out = 0;
      return;
    end
    m_pend = 0;
    m_rv   = 0;
    sat = v && (d == SATV);
    ev  = int'(l) + int'(sat);
    m_lost = (m_lost + ev > LMAX) ? LMAX : m_lost + ev;
    if (v && !sat) q.push_back(d);
    if (q.size() == N) begin
      mn = q[0]; mx = q[0]; sum = 0;
      foreach (q[i]) begin
        if (q[i] < mn) mn = q[i];
        if (q[i] > mx) mx = q[i];
        sum += q[i];
      end
      m_min = mn; m_max = mx; m_avg = int'(sum / N);
      m_lost_out = m_lost;
      m_rv = 1;
      q.delete();
      m_lost = 0;
      m_pend = 1;
    end
  endtask

  function automatic int dbg_exp(input logic [1:0] sel, input int mn, input int mx,
                                 input int av, input int lo, input int cnt);
    case (sel)
      2'b00:   return mn & 32'hFFFFF;
      2'b01:   return mx & 32'hFFFFF;
      2'b10:   return av & 32'hFFFFF;
      default: return ((lo & 32'hFFF) << 8) | (cnt & 32'hFF);
    endcase
  endfunction

  task automatic cycle(input bit v, input int d, input bit l, input bit c);
    bus.sample_valid = v;
    bus.sample_delay = d[19:0];
    bus.sample_lost  = l;
    clr              = c;
    @(posedge clk);
    model_step(rst, c, v, d, l);
    #1;
    bus.sample_valid = 1'b0;
    bus.sample_lost  = 1'b0;
    clr              = 1'b0;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".valid"}, 32'(bus.result_valid), 32'(m_rv));
    check({tag, ".min"},   32'(bus.min_delay),    32'(m_min));
    check({tag, ".max"},   32'(bus.max_delay),    32'(m_max));
    check({tag, ".avg"},   32'(bus.avg_delay),    32'(m_avg));
    check({tag, ".lost"},  32'(bus.lost_count),   32'(m_lost_out));
    check({tag, ".dbg"},   32'(dbg_word),
          32'(dbg_exp(dbg_sel, m_min, m_max, m_avg, m_lost_out, m_pend ? N : q.size())));
  endtask

  task automatic add(input bit v, input int d, input bit l, input bit c, input bit rv,
                     input int mn, input int mx, input int av, input int lo, input int cnt);
    vec_t t;
    t.v = v; t.d = d; t.l = l; t.c = c; t.rv = rv;
    t.mn = mn; t.mx = mx; t.av = av; t.lo = lo; t.cnt = cnt;
    tbl.push_back(t);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; dbg_sel = 2'b11; hist_addr = 3'd0;
    bus.sample_valid = 1'b0; bus.sample_delay = '0; bus.sample_lost = 1'b0;
    cycle(1'b0, 0, 1'b0, 1'b0);
    cycle(1'b1, 33, 1'b1, 1'b0);
    check("reset.valid", 32'(bus.result_valid), 32'd0);
    check("reset.min",   32'(bus.min_delay),    32'd0);
    check("reset.lost",  32'(bus.lost_count),   32'd0);
    check("reset.dbg",   32'(dbg_word),         32'd0);
    rst = 1'b0;

    // v, d, lost, clear | valid, min, max, avg, lost, window count
    add(1, 10, 0, 0,  0,  0,   0,   0, 0, 1);
    add(1, 20, 0, 0,  0,  0,   0,   0, 0, 2);
    add(1, 30, 0, 0,  0,  0,   0,   0, 0, 3);
    add(1, 40, 0, 0,  1, 10,  40,  25, 0, 4);
    add(0,  0, 0, 0,  0, 10,  40,  25, 0, 0);
    add(1,  7, 0, 0,  0, 10,  40,  25, 0, 1);
    add(0,  0, 1, 0,  0, 10,  40,  25, 0, 1);
    add(1,  8, 0, 0,  0, 10,  40,  25, 0, 2);
    add(1,  8, 1, 0,  0, 10,  40,  25, 0, 3);
    add(1,  8, 0, 0,  1,  7,   8,   7, 2, 4);
    add(0,  0, 0, 0,  0,  7,   8,   7, 2, 0);
    add(1, 50, 0, 0,  0,  7,   8,   7, 2, 1);
    add(1, SATV, 0, 0, 0, 7,   8,   7, 2, 1);
    add(1, 60, 0, 0,  0,  7,   8,   7, 2, 2);
    add(1, 70, 0, 0,  0,  7,   8,   7, 2, 3);
    add(1, 80, 0, 0,  1, 50,  80,  65, 1, 4);
    add(1,100, 0, 0,  0, 50,  80,  65, 1, 1);
    add(1,110, 0, 0,  0, 50,  80,  65, 1, 2);
    add(1,120, 0, 0,  0, 50,  80,  65, 1, 3);
    add(1,130, 0, 0,  1,100, 130, 115, 0, 4);
    add(1,  1, 0, 0,  0,100, 130, 115, 0, 1);
    add(1,  2, 0, 0,  0,100, 130, 115, 0, 2);
    add(1,  3, 0, 0,  0,100, 130, 115, 0, 3);
    add(0,  0, 0, 1,  0,  0,   0,   0, 0, 0);
    add(1,  5, 0, 0,  0,  0,   0,   0, 0, 1);
    add(1,  5, 0, 0,  0,  0,   0,   0, 0, 2);
    add(1,  5, 0, 0,  0,  0,   0,   0, 0, 3);
    add(1,  5, 0, 0,  1,  5,   5,   5, 0, 4);

    dbg_sel = 2'b11;
    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].c);
      check($sformatf("tbl%0d.valid", i), 32'(bus.result_valid), 32'(tbl[i].rv));
      check($sformatf("tbl%0d.min", i),   32'(bus.min_delay),    32'(tbl[i].mn));
      check($sformatf("tbl%0d.max", i),   32'(bus.max_delay),    32'(tbl[i].mx));
      check($sformatf("tbl%0d.avg", i),   32'(bus.avg_delay),    32'(tbl[i].av));
      check($sformatf("tbl%0d.lost", i),  32'(bus.lost_count),   32'(tbl[i].lo));
      check($sformatf("tbl%0d.dbg", i),   32'(dbg_word),
            32'(((tbl[i].lo & 32'hFFF) << 8) | tbl[i].cnt));
    end

    // Lost counter saturates rather than wrapping.
    cycle(1'b0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 300; i++) cycle(1'b0, 0, 1'b1, 1'b0);
    for (int i = 0; i < N; i++) cycle(1'b1, 9, 1'b0, 1'b0);
    check("lostsat.valid", 32'(bus.result_valid), 32'd1);
    check("lostsat.lost",  32'(bus.lost_count),   32'(LMAX));
    check("lostsat.avg",   32'(bus.avg_delay),    32'd9);

    // Randomized run against the window model.
    for (int i = 0; i < 4000; i++) begin
      bit v, l, c;
      int d, r;
      v = ($urandom_range(0, 9) < 6);
      l = ($urandom_range(0, 99) < 15);
      c = ($urandom_range(0, 199) == 0);
      r = $urandom_range(0, 9);
      if (r == 0 && !l)  d = SATV;
      else if (r < 4)    d = $urandom_range(0, 100);
      else               d = int'($urandom & 32'h000FFFFF);
      dbg_sel = 2'($urandom_range(0, 3));
      cycle(v, d, l, c);
      check_model($sformatf("rnd%0d", i));
    end

`ifdef DELAY_STATS_HIST_EN
    cycle(1'b0, 0, 1'b0, 1'b1);
    cycle(1'b1, 32'h15,  1'b0, 1'b0);
    cycle(1'b1, 32'h18,  1'b0, 1'b0);
    cycle(1'b1, 32'h200, 1'b0, 1'b0);
    hist_addr = 3'd1;
    cycle(1'b0, 0, 1'b0, 1'b0);
    check("hist.bin1", 32'(hist_data), 32'd2);
    hist_addr = 3'd7;
    #1;
    check("hist.registered", 32'(hist_data), 32'd2);
    cycle(1'b0, 0, 1'b0, 1'b0);
    check("hist.bin7", 32'(hist_data), 32'd1);
    hist_addr = 3'd0;
    cycle(1'b0, 0, 1'b0, 1'b0);
    check("hist.bin0", 32'(hist_data), 32'd0);
`else
    hist_addr = 3'd5;
    cycle(1'b1, 32'h55, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b0);
    check("hist.tied", 32'(hist_data), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/delay_stats.md
Name: delay_stats

Overview:
- Downstream consumer of the latency timer on the tx_clk domain.
- Collects per-frame delay measurements into fixed-size windows of 2^WIN_LOG2 samples.
- At the end of each window, publishes min, max and average delay plus the count of lost frames.
- Publishes results through registered outputs and a 20-bit debug word mux that feeds the debug_data pins.

Parameters:
- DELAY_W, 20, width of one delay sample, in tx_clk cycles.
- WIN_LOG2, 4, log2 of samples per window; legal range 1..8.
- LOST_W, 8, width of the per-window saturating lost-frame counter.
- BIN_SHIFT, 4, histogram bin index = sample_delay[BIN_SHIFT+2:BIN_SHIFT] (feature build only).

Ports:
- tx_clk  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- clear  in  1  synchronous flush of window and results; reset has priority.
- sample_valid  in  1  one-cycle pulse; sample_delay is valid this cycle.
- sample_delay  in  DELAY_W  measured delay.
- sample_lost  in  1  one-cycle pulse; the frame was never caught.
- result_valid  out  1  one-cycle pulse when the result registers update.
- min_delay  out  DELAY_W  window minimum.
- max_delay  out  DELAY_W  window maximum.
- avg_delay  out  DELAY_W  window sum >> WIN_LOG2, truncated.
- lost_count  out  LOST_W  lost frames in the published window.
- dbg_sel  in  2  debug mux select.
- dbg_word  out  20  00=min, 01=max, 10=avg (each the low 20 bits); 11={lost_count zero-extended/truncated to 12 bits, window sample count zero-extended to 8 bits}.
- hist_rd_addr  in  3  histogram bin select.
- hist_rd_data  out  16  histogram bin count.

Behaviour:
- Reset or clear:
  - All outputs = 0.
  - State = EMPTY.
  - Window registers (wmin, wmax, wsum of DELAY_W+WIN_LOG2 bits, wcnt of WIN_LOG2+1 bits, wlost) = 0.
- A sample equal to all-ones (timer saturation) is treated exactly as sample_lost and never enters min/max/sum.
- State EMPTY:
  - Valid sample: wmin = wmax = wsum = sample, wcnt = 1, go to ACCUM.
  - sample_lost alone: wlost++, stay in EMPTY.
- State ACCUM:
  - Valid sample: wmin = min(wmin, s), wmax = max(wmax, s), wsum += s, wcnt++.
  - When wcnt reaches 2^WIN_LOG2 in that cycle, go to PUBLISH.
- State PUBLISH (exactly one cycle):
  - Result registers load from the window registers; avg = wsum >> WIN_LOG2.
  - result_valid = 1.
  - Window registers reset.
  - A valid sample arriving in this cycle seeds the next window (wcnt = 1, go to ACCUM); otherwise go to EMPTY.
  - A sample_lost in this cycle counts toward the next window.
  - Latency: result_valid asserts one cycle after the cycle holding the final sample.
- sample_valid and sample_lost in the same cycle: both take effect.
- wlost saturates at 2^LOST_W-1; it never wraps.
- wsum cannot overflow: its width is DELAY_W+WIN_LOG2 bits.
- Result registers hold their values until the next PUBLISH, clear, or reset.
- dbg_word is combinational from registered values.
- Reset or clear asserted mid-window: the partial window is discarded and no result_valid is produced.

Optional Feature:
- Macro: DELAY_STATS_HIST_EN.
- Defined:
  - 8 bins of 16-bit saturating counters.
  - Bin = sample_delay[BIN_SHIFT+2:BIN_SHIFT]; a sample whose bits above BIN_SHIFT+2 are nonzero goes to bin 7.
  - Only valid samples (not lost, not all-ones) are binned.
  - Bins are cleared only by reset or clear, never at window publish.
  - hist_rd_data is registered, one cycle after hist_rd_addr.
- Undefined: hist_rd_data is tied to 0 and no counters exist.

Decomposition:
- Shared package delay_tester_pkg holds:
  - DELAY_W default.
  - State encoding EMPTY/ACCUM/PUBLISH.
  - dbg_sel codes.
  - The all-ones saturation constant.
- One sub-module, delay_hist: the bin counters and read port, instantiated only under DELAY_STATS_HIST_EN.

Test Plan:
- Window publish: WIN_LOG2=2, samples 10, 20, 30, 40 on consecutive cycles -> result_valid one cycle after the 40, min=10, max=40, avg=25, lost_count=0.
- Truncation and lost frames: samples 7, 8, 8, 8 with two sample_lost pulses, one coincident with the 8 -> avg=7 (31>>2), lost_count=2.
- Saturation value: a sample of 0xFFFFF mid-window -> counted as lost, wcnt unchanged, max unaffected.
- Back-to-back windows: a new sample presented in the PUBLISH cycle -> next window completes after 3 more samples; no sample dropped.
- Mid-window flush: clear after 3 of 4 samples -> no result_valid, outputs 0; then 4 samples of 5 -> min=max=avg=5.
- Histogram (HIST_EN, BIN_SHIFT=4): samples 0x15, 0x18, 0x200 -> bin 1=2, bin 7=1; hist_rd_data valid one cycle after the address is applied.
